booth_mul_seq: RTL and testbench
================================

Name: booth_mul_seq

Overview:
- Sequential, parametrised Booth multiplier for the CPU datapath MUL path; feeds the HI/LO registers.
- Computes the full 2*WIDTH-bit product, one recoding step per clock, under a start/busy/done handshake.
- Supports both signed and unsigned operands, with optional radix-4 recoding.
- Successor to the combinational 32-bit Booth unit; frees the ALU critical path.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with start.
- abort  input  1  synchronous cancel of an in-flight operation.
- multiplicand  input  WIDTH  M operand; latched with start.
- multiplier  input  WIDTH  Q operand; latched with start.
- busy  output  1  high in RUN state.
- done  output  1  one-cycle pulse when the product is valid.
- product_hi  output  WIDTH  upper half of the product.
- product_lo  output  WIDTH  lower half of the product.

Behaviour:
- Reset (reset_n low, at any time including mid-operation):
  - state = IDLE; busy = 0, done = 0, product_hi = 0, product_lo = 0.
  - Step counter and internal registers cleared.
- States and transitions:
  - IDLE: stays here until start is sampled high.
  - RUN: one Booth step per cycle for N cycles, then moves to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- Operand extension at start:
  - Operands are extended to WIDTH+2 bits: sign-extended if signed_mode = 1, zero-extended if 0.
  - This makes unsigned operands correct under Booth recoding.
- Accumulator layout: {A[WIDTH+2], Q[WIDTH+2], q_minus1}.
  - A starts at 0; q_minus1 starts at 0.
- Radix-2 step (default):
  - Pair {Q[0], q_minus1} = 10: subtract M from A. Pair = 01: add M to A. Otherwise A is unchanged.
  - Then arithmetic right shift of the whole accumulator by 1.
  - N = WIDTH+1.
- Arithmetic: all add/subtract operations are done at WIDTH+2 bits, with carry-out discarded.
- Result:
  - The product is the low 2*WIDTH bits of {A, Q} after the final step, registered into product_hi/product_lo on entry to DONE.
- Latency: done goes high exactly N+1 cycles after the edge that accepts start (WIDTH=32 radix-2: 34).
- Output holding:
  - product_hi/product_lo hold their value until the next completed operation.
  - They are NOT cleared by a new start or by abort.
- Handshake rules:
  - start while busy = 1 or during DONE: ignored; latched operands are unaffected.
  - start held high continuously: a new operation is accepted on the first IDLE cycle, i.e. back-to-back with a 1-cycle gap.
  - Operand/mode inputs may change freely after the accepting edge.
- abort:
  - When sampled high in RUN: return to IDLE next cycle, done is not asserted, and the product outputs are unchanged.
  - Ignored in IDLE and DONE.
  - abort and start high together in IDLE: start wins.
- Step counter: counts down from N-1 to 0 and never wraps; RUN exits when it reaches 0.

Optional Feature:
- Macro: BOOTH_RADIX4_EN.
- When defined:
  - Radix-4 (modified Booth) recoding; each step examines {Q[1], Q[0], q_minus1}.
  - Selects 0, +M, +2M, -M or -2M, then arithmetic right shift by 2.
  - A is widened to WIDTH+3 bits internally to hold 2M.
  - N = WIDTH/2+1 (WIDTH=32: done 18 cycles after start).
  - All other behaviour and ports are identical.
- When undefined: radix-2 as above.

Test Plan:
- WIDTH=32, signed_mode=1, M=0xFFFFFFF9 (-7), Q=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 34 cycles after start (18 with BOOTH_RADIX4_EN).
- signed_mode=0, M=Q=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; the same operands with signed_mode=1 -> hi=0x00000000, lo=0x00000001.
- signed_mode=1, M=Q=0x80000000 -> hi=0x40000000, lo=0x00000000; and M=0x80000000, Q=0x00000001 -> hi=0xFFFFFFFF, lo=0x80000000.
- Start M=5, Q=6; pulse start with M=9, Q=9 while busy -> only 30 (lo=0x0000001E) produced, single done pulse; start held high afterwards -> second op accepted the cycle after done.
- Complete 3×4 (lo=12), then start 7×7 and assert abort at step 10 -> no done, busy drops next cycle, outputs still lo=12.
- Drop reset_n asynchronously mid-RUN -> busy, done and product outputs are 0 immediately; after release, a fresh 2×3 yields lo=6 with nominal latency.

Source files
------------

// File: rtl/booth_mul_seq.sv
// Sequential Booth multiplier with start/busy/done handshake, signed or unsigned operands.
// Define BOOTH_RADIX4_EN for radix-4 (modified Booth) recoding; radix-2 otherwise.
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic             abort,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int XW = WIDTH + 2;
`ifdef BOOTH_RADIX4_EN
  localparam int AW = WIDTH + 3;
  localparam int N  = WIDTH / 2 + 1;
`else
  localparam int AW = WIDTH + 2;
  localparam int N  = WIDTH + 1;
`endif
  localparam int CW = $clog2(N);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [XW-1:0]    m_reg;
  logic [AW-1:0]    a_reg;
  logic [XW-1:0]    q_reg;
  logic             qm1_reg;
  logic [WIDTH-1:0] prod_hi_reg;
  logic [WIDTH-1:0] prod_lo_reg;

  logic [XW-1:0]      m_ext;
  logic [XW-1:0]      q_ext;
  logic [AW-1:0]      a_sum;
  logic [AW-1:0]      a_next;
  logic [XW-1:0]      q_next;
  logic               qm1_next;
  logic [2*WIDTH-1:0] prod_next;

  assign m_ext = {{2{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
  assign q_ext = {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier};

`ifdef BOOTH_RADIX4_EN
  logic [AW-1:0] m_wide;
  logic [AW-1:0] m_dbl;

  assign m_wide = {m_reg[XW-1], m_reg};
  assign m_dbl  = {m_wide[AW-2:0], 1'b0};

  always_comb begin
    a_sum = a_reg;
    case ({q_reg[1:0], qm1_reg})
      3'b001, 3'b010: a_sum = a_reg + m_wide;
      3'b011:         a_sum = a_reg + m_dbl;
      3'b100:         a_sum = a_reg - m_dbl;
      3'b101, 3'b110: a_sum = a_reg - m_wide;
      default:        a_sum = a_reg;
    endcase
    a_next   = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
    q_next   = {a_sum[1:0], q_reg[XW-1:2]};
    qm1_next = q_reg[1];
  end

  // All WIDTH+2 multiplier bits are consumed, so {A, Q} holds the product directly.
  assign prod_next = {a_next[WIDTH-3:0], q_next};
`else
  always_comb begin
    a_sum = a_reg;
    case ({q_reg[0], qm1_reg})
      2'b10:   a_sum = a_reg - m_reg;
      2'b01:   a_sum = a_reg + m_reg;
      default: a_sum = a_reg;
    endcase
    a_next   = {a_sum[AW-1], a_sum[AW-1:1]};
    q_next   = {a_sum[0], q_reg[XW-1:1]};
    qm1_next = q_reg[0];
  end

  // After WIDTH+1 steps Q[0] still holds an unconsumed extension bit; the product starts at Q[1].
  assign prod_next = {a_next[WIDTH-2:0], q_next[XW-1:1]};
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      m_reg       <= '0;
      a_reg       <= '0;
      q_reg       <= '0;
      qm1_reg     <= 1'b0;
      prod_hi_reg <= '0;
      prod_lo_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            cnt_reg   <= CW'(N - 1);
            m_reg     <= m_ext;
            a_reg     <= '0;
            q_reg     <= q_ext;
            qm1_reg   <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state_reg <= IDLE;
          end else begin
            a_reg   <= a_next;
            q_reg   <= q_next;
            qm1_reg <= qm1_next;
            if (cnt_reg == '0) begin
              state_reg   <= DONE;
              prod_hi_reg <= prod_next[2*WIDTH-1:WIDTH];
              prod_lo_reg <= prod_next[WIDTH-1:0];
            end else begin
              cnt_reg <= cnt_reg - CW'(1);
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy       = (state_reg == RUN);
  assign done       = (state_reg == DONE);
  assign product_hi = prod_hi_reg;
  assign product_lo = prod_lo_reg;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and random checks of booth_mul_seq (WIDTH=32) against a plain-arithmetic product model.
// Honours BOOTH_RADIX4_EN for the expected latency.
module tb_booth_mul_seq;

`ifdef BOOTH_RADIX4_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 34;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        busy;
  logic        done;
  logic [31:0] product_hi;
  logic [31:0] product_lo;

  int total = 0;
  int bad = 0;

  booth_mul_seq #(.WIDTH(32)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .signed_mode(signed_mode),
    .abort(abort),
    .multiplicand(multiplicand),
    .multiplier(multiplier),
    .busy(busy),
    .done(done),
    .product_hi(product_hi),
    .product_lo(product_lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q, input logic sm);
    longint sa;
    longint sb;
    logic [63:0] ua;
    logic [63:0] ub;
    if (sm) begin
      sa = $signed(m);
      sb = $signed(q);
      return 64'(sa * sb);
    end
    ua = {32'd0, m};
    ub = {32'd0, q};
    return ua * ub;
  endfunction

  // Issue one operation, scramble the inputs after acceptance, return latency in cycles.
  task automatic run_op(input logic [31:0] m, input logic [31:0] q, input logic sm, output int lat);
    multiplicand = m;
    multiplier   = q;
    signed_mode  = sm;
    start        = 1'b1;
    @(posedge clock); #1;
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    signed_mode  = ~sm;
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                          input logic sm, input logic [63:0] exp);
    int lat;
    run_op(m, q, sm, lat);
    $display("op %s m=%h q=%h signed=%0d -> hi=%h lo=%h after %0d cycles",
             tag, m, q, sm, product_hi, product_lo, lat);
    chk({tag, ".latency"}, 64'(lat), 64'(LAT));
    chk({tag, ".hi"}, {32'd0, product_hi}, {32'd0, exp[63:32]});
    chk({tag, ".lo"}, {32'd0, product_lo}, {32'd0, exp[31:0]});
    @(posedge clock); #1;
    chk({tag, ".done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int n;
    int done_at;
    logic seen_done;
    logic [31:0] rm;
    logic [31:0] rq;
    logic rs;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst.busy", {63'd0, busy}, 64'd0);
    chk("rst.done", {63'd0, done}, 64'd0);
    chk("rst.hi", {32'd0, product_hi}, 64'd0);
    chk("rst.lo", {32'd0, product_lo}, 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Directed corner operands
    check_op("neg7x3", 32'hFFFF_FFF9, 32'h0000_0003, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    check_op("umax_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    check_op("sneg1_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    check_op("smin_sq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    check_op("smin_x1", 32'h8000_0000, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_8000_0000);

    // Random operands against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      rm = $urandom;
      rq = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 6 == 1) rm = 32'h8000_0000;
      if (i % 6 == 2) rq = 32'h7FFF_FFFF;
      if (i % 6 == 3) rq = 32'h0;
      check_op($sformatf("rand%0d", i), rm, rq, rs, ref_mul(rm, rq, rs));
    end

    // start while busy is ignored; start held high is accepted after DONE
    multiplicand = 32'd5;
    multiplier   = 32'd6;
    signed_mode  = 1'b0;
    start        = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 1;
    done_at = 0;
    while (done_at == 0 && n < 200) begin
      if (n == 5) begin start = 1'b1; multiplicand = 32'd9; multiplier = 32'd9; end
      if (n == 6) start = 1'b0;
      if (n == LAT - 4) begin start = 1'b1; multiplicand = 32'd4; multiplier = 32'd8; end
      @(posedge clock); #1;
      n++;
      if (done) done_at = n;
    end
    $display("op busy_start m=5 q=6 -> hi=%h lo=%h after %0d cycles", product_hi, product_lo, done_at);
    chk("busy_start.latency", 64'(done_at), 64'(LAT));
    chk("busy_start.hi", {32'd0, product_hi}, 64'd0);
    chk("busy_start.lo", {32'd0, product_lo}, 64'd30);
    @(posedge clock); #1;
    chk("held.gap_busy", {63'd0, busy}, 64'd0);
    chk("held.gap_done", {63'd0, done}, 64'd0);
    @(posedge clock); #1;
    chk("held.accepted", {63'd0, busy}, 64'd1);
    start = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    n = 1;
    while (!done && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    $display("op held m=4 q=8 -> hi=%h lo=%h after %0d cycles", product_hi, product_lo, n);
    chk("held.latency", 64'(n), 64'(LAT));
    chk("held.lo", {32'd0, product_lo}, 64'd32);
    @(posedge clock); #1;

    // abort mid-run leaves previous product intact
    check_op("3x4", 32'd3, 32'd4, 1'b0, 64'd12);
    multiplicand = 32'd7;
    multiplier   = 32'd7;
    start        = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 1;
    while (n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    chk("abort.busy", {63'd0, busy}, 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen_done |= done;
      @(posedge clock); #1;
    end
    $display("op abort m=7 q=7 -> hi=%h lo=%h", product_hi, product_lo);
    chk("abort.no_done", {63'd0, seen_done}, 64'd0);
    chk("abort.hi", {32'd0, product_hi}, 64'd0);
    chk("abort.lo", {32'd0, product_lo}, 64'd12);

    // asynchronous reset mid-run
    multiplicand = 32'd7;
    multiplier   = 32'd7;
    start        = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    $display("op async_reset -> busy=%0d done=%0d hi=%h lo=%h", busy, done, product_hi, product_lo);
    chk("arst.busy", {63'd0, busy}, 64'd0);
    chk("arst.done", {63'd0, done}, 64'd0);
    chk("arst.hi", {32'd0, product_hi}, 64'd0);
    chk("arst.lo", {32'd0, product_lo}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_op("post_rst_2x3", 32'd2, 32'd3, 1'b1, 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
